// File: rtl/dsp_reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : dsp_reset_sequencer_if
// Description : ISA-side bus bundle for the DSP reset sequencer. Carries the
//               arbiter pacing/enable strobes, read data, and the tri-stated
//               address/data/direction/accepted drivers.
// Revision    : 1.0 - initial release
// ============================================================================
interface dsp_reset_sequencer_if;
    logic        bus_step;
    logic        enable;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic [15:0] address;
    logic        data_dir;
    logic        accepted;

    // Sequencer side: drives the bus, samples pacing and read data
    modport master (
        input  bus_step, enable, data_in,
        output data_out, address, data_dir, accepted
    );

    // Arbiter / bus-model side
    modport slave (
        output bus_step, enable, data_in,
        input  data_out, address, data_dir, accepted
    );
endinterface
`default_nettype wire

// File: rtl/dsp_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : dsp_reset_sequencer
// Description : Sound Blaster DSP reset handshake with configurable reset
//               hold, poll timeout and retry, followed by an optional E1h
//               version read. Bus outputs are Moore, registered, and
//               tri-stated by enable.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_reset_sequencer #(
    parameter logic [15:0] BASE_ADDRESS        = 16'h0220,
    parameter int          CNT_W               = 16,
    parameter int          RESET_HOLD_CYCLES   = 150,
    parameter int          POLL_TIMEOUT_CYCLES = 5000,
    parameter int          MAX_RETRIES         = 3,
    parameter int          READ_VERSION        = 1
) (
    input  wire logic              sys_clock,
    input  wire logic              reset_n,
    input  wire logic              start,
    dsp_reset_sequencer_if.master  bus,
    output logic                   busy,
    output logic                   error,
    output logic [2:0]             retry_count,
    output logic [15:0]            dsp_version
);

    localparam logic [15:0]      c_addr_rst   = BASE_ADDRESS + 16'h0006;
    localparam logic [15:0]      c_addr_rdata = BASE_ADDRESS + 16'h000A;
    localparam logic [15:0]      c_addr_wcmd  = BASE_ADDRESS + 16'h000C;
    localparam logic [15:0]      c_addr_rstat = BASE_ADDRESS + 16'h000E;
    localparam logic [CNT_W-1:0] c_poll_last  = CNT_W'(POLL_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W:0]   c_hold_len   = (CNT_W+1)'(RESET_HOLD_CYCLES);
    localparam logic [CNT_W:0]   c_one        = (CNT_W+1)'(1);
    localparam logic [2:0]       c_max_retry  = 3'(MAX_RETRIES);

    typedef enum logic [3:0] {
        S_W1   = 4'd0,  S_HOLD = 4'd1,  S_W0  = 4'd2,  S_PRD = 4'd3,
        S_RAA  = 4'd4,  S_PWR  = 4'd5,  S_WE1 = 4'd6,  S_PV1 = 4'd7,
        S_RV1  = 4'd8,  S_PV2  = 4'd9,  S_RV2 = 4'd10, S_DONE = 4'd11,
        S_FAIL = 4'd12
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       retry_q, retry_d;
    logic             error_q, error_d;
    logic [15:0]      ver_q, ver_d;
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      dout_q, dout_d;
    logic             dir_q, dir_d;
    logic             acc_q, acc_d;
    logic             busy_q, busy_d;
    logic             w_poll;
    logic             w_hold_done;

    // Poll states are the only ones subject to the timeout
    assign w_poll = (state_q == S_PRD) || (state_q == S_RAA) || (state_q == S_PWR) ||
                    (state_q == S_PV1) || (state_q == S_PV2);

    // Compare the post-increment count so HOLD lasts exactly RESET_HOLD_CYCLES clocks
    assign w_hold_done = (({1'b0, cnt_q} + c_one) >= c_hold_len);

    // Next-state, counter, retry/error and version-capture logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        error_d = error_q;
        ver_d   = ver_q;
        case (state_q)
            S_W1:   if (bus.bus_step) state_d = S_HOLD;
            S_HOLD: if (bus.bus_step && w_hold_done) state_d = S_W0;
            S_W0:   if (bus.bus_step) state_d = S_PRD;
            S_PRD:  if (bus.bus_step && bus.data_in[7]) state_d = S_RAA;
            S_RAA:  if (bus.bus_step && (bus.data_in == 16'h00AA))
                        state_d = (READ_VERSION != 0) ? S_PWR : S_DONE;
            S_PWR:  if (bus.bus_step && !bus.data_in[7]) state_d = S_WE1;
            S_WE1:  if (bus.bus_step) state_d = S_PV1;
            S_PV1:  if (bus.bus_step && bus.data_in[7]) state_d = S_RV1;
            S_RV1:  if (bus.bus_step) begin
                        state_d      = S_PV2;
                        ver_d[15:8]  = bus.data_in[7:0];
                    end
            S_PV2:  if (bus.bus_step && bus.data_in[7]) state_d = S_RV2;
            S_RV2:  if (bus.bus_step) begin
                        state_d      = S_DONE;
                        ver_d[7:0]   = bus.data_in[7:0];
                    end
            default: state_d = state_q;
        endcase

        // A qualifying exit on the same edge wins over the timeout
        if (w_poll && (cnt_q == c_poll_last) && (state_d == state_q)) begin
            if (retry_q < c_max_retry) begin
                retry_d = retry_q + 3'd1;
                state_d = S_W1;
            end else begin
                error_d = 1'b1;
                state_d = S_FAIL;
            end
        end

        if (state_d != state_q)
            cnt_d = '0;
        else if ((w_poll || (state_q == S_HOLD)) && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;

        // Restart overrides everything
        if (start) begin
            state_d = S_W1;
            cnt_d   = '0;
            retry_d = '0;
            error_d = 1'b0;
            ver_d   = '0;
        end
    end

    // Moore output decode of the upcoming state, registered below
    always_comb begin
        addr_d = c_addr_rst;
        dout_d = 16'h0000;
        dir_d  = 1'b1;
        case (state_d)
            S_W1, S_HOLD: dout_d = 16'h0001;
            S_PRD, S_PV1, S_PV2: begin addr_d = c_addr_rstat; dir_d = 1'b0; end
            S_RAA, S_RV1, S_RV2: begin addr_d = c_addr_rdata; dir_d = 1'b0; end
            S_PWR:  begin addr_d = c_addr_wcmd; dir_d = 1'b0; end
            S_WE1:  begin addr_d = c_addr_wcmd; dout_d = 16'h00E1; end
            default: ;
        endcase
        acc_d  = (state_d == S_DONE);
        busy_d = (state_d != S_DONE) && (state_d != S_FAIL);
    end

    // State and registered outputs; reset lands in W1 with its outputs already valid
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_W1;
            cnt_q   <= '0;
            retry_q <= '0;
            error_q <= 1'b0;
            ver_q   <= '0;
            addr_q  <= c_addr_rst;
            dout_q  <= 16'h0001;
            dir_q   <= 1'b1;
            acc_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            error_q <= error_d;
            ver_q   <= ver_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            dir_q   <= dir_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.address  = bus.enable ? addr_q : 16'bz;
    assign bus.data_out = bus.enable ? dout_q : 16'bz;
    assign bus.data_dir = bus.enable ? dir_q  : 1'bz;
    assign bus.accepted = bus.enable ? acc_q  : 1'bz;

    assign busy        = busy_q;
    assign error       = error_q;
    assign retry_count = retry_q;
    assign dsp_version = ver_q;

endmodule
`default_nettype wire

// File: tb/tb_dsp_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_reset_sequencer
// Description : Self-checking bench for dsp_reset_sequencer: table-driven
//               nominal handshake through a scoreboard queue, plus directed
//               sequences for hold timing, timeout/retry, exhaustion, edge
//               race, async reset, restart and tri-state release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_reset_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        error;
    logic [2:0]  retry_count;
    logic [15:0] dsp_version;
    int          checks;
    int          failures;

    dsp_reset_sequencer_if bus ();

    dsp_reset_sequencer #(
        .BASE_ADDRESS        (16'h0220),
        .CNT_W               (16),
        .RESET_HOLD_CYCLES   (4),
        .POLL_TIMEOUT_CYCLES (20),
        .MAX_RETRIES         (2),
        .READ_VERSION        (1)
    ) dut (
        .sys_clock   (clk),
        .reset_n     (rst_n),
        .start       (start),
        .bus         (bus),
        .busy        (busy),
        .error       (error),
        .retry_count (retry_count),
        .dsp_version (dsp_version)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {data_in, bus_step} applied on one edge and {address, data_out, data_dir, accepted, busy} expected after it
    typedef struct packed {
        logic [15:0] din;
        logic        step;
        logic [34:0] exp;
    } vec_t;

    vec_t        vec [15];
    logic [34:0] sb [$];

    function automatic logic [34:0] obs();
        return {bus.address, bus.data_out, bus.data_dir, bus.accepted, busy};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick(input logic [15:0] din, input logic step);
        bus.data_in  = din;
        bus.bus_step = step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        start        = 1'b0;
        bus.data_in  = 16'h0000;
        bus.bus_step = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic apply_rows(input int n);
        logic [34:0] e;
        for (int i = 0; i < n; i++) begin
            sb.push_back(vec[i].exp);
            tick(vec[i].din, vec[i].step);
            e = sb.pop_front();
            chk($sformatf("row%0d", i), 64'(obs()), 64'(e));
        end
    endtask

    // Hard stop if something hangs
    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks   = 0;
        failures = 0;

        //           din       step  addr      dout      dir  acc  busy
        vec[0]  = '{16'h0000, 1'b1, {16'h0226, 16'h0001, 1'b1, 1'b0, 1'b1}}; // HOLD
        vec[1]  = '{16'h0000, 1'b1, {16'h0226, 16'h0001, 1'b1, 1'b0, 1'b1}}; // HOLD
        vec[2]  = '{16'h0000, 1'b1, {16'h0226, 16'h0001, 1'b1, 1'b0, 1'b1}}; // HOLD
        vec[3]  = '{16'h0000, 1'b1, {16'h0226, 16'h0001, 1'b1, 1'b0, 1'b1}}; // HOLD
        vec[4]  = '{16'h0000, 1'b1, {16'h0226, 16'h0000, 1'b1, 1'b0, 1'b1}}; // W0
        vec[5]  = '{16'h0000, 1'b1, {16'h022E, 16'h0000, 1'b0, 1'b0, 1'b1}}; // PRD
        vec[6]  = '{16'h0080, 1'b1, {16'h022A, 16'h0000, 1'b0, 1'b0, 1'b1}}; // RAA
        vec[7]  = '{16'h00AA, 1'b1, {16'h022C, 16'h0000, 1'b0, 1'b0, 1'b1}}; // PWR
        vec[8]  = '{16'h0000, 1'b1, {16'h022C, 16'h00E1, 1'b1, 1'b0, 1'b1}}; // WE1
        vec[9]  = '{16'h0000, 1'b1, {16'h022E, 16'h0000, 1'b0, 1'b0, 1'b1}}; // PV1
        vec[10] = '{16'h0080, 1'b1, {16'h022A, 16'h0000, 1'b0, 1'b0, 1'b1}}; // RV1
        vec[11] = '{16'h0004, 1'b1, {16'h022E, 16'h0000, 1'b0, 1'b0, 1'b1}}; // PV2
        vec[12] = '{16'h0080, 1'b1, {16'h022A, 16'h0000, 1'b0, 1'b0, 1'b1}}; // RV2
        vec[13] = '{16'h0005, 1'b1, {16'h0226, 16'h0000, 1'b1, 1'b1, 1'b0}}; // DONE
        vec[14] = '{16'h0000, 1'b1, {16'h0226, 16'h0000, 1'b1, 1'b1, 1'b0}}; // DONE holds

        bus.enable   = 1'b1;
        rst_n        = 1'b0;
        start        = 1'b0;
        bus.data_in  = 16'h0000;
        bus.bus_step = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset state
        chk("reset_outputs", 64'(obs()), 64'({16'h0226, 16'h0001, 1'b1, 1'b0, 1'b1}));
        chk("reset_retry", 64'(retry_count), 64'd0);
        chk("reset_error", 64'(error), 64'd0);
        chk("reset_version", 64'(dsp_version), 64'h0000);
        rst_n = 1'b1;

        // Nominal handshake
        apply_rows(15);
        chk("nom_version", 64'(dsp_version), 64'h0405);
        chk("nom_retry", 64'(retry_count), 64'd0);
        chk("nom_error", 64'(error), 64'd0);

        // Restart from DONE
        start = 1'b1;
        tick(16'h0000, 1'b1);
        start = 1'b0;
        chk("start_outputs", 64'(obs()), 64'({16'h0226, 16'h0001, 1'b1, 1'b0, 1'b1}));
        chk("start_version", 64'(dsp_version), 64'h0000);

        // HOLD waits for bus_step once the count is satisfied
        tick(16'h0000, 1'b1);                               // -> HOLD
        for (int i = 0; i < 3; i++) tick(16'h0000, 1'b1);   // count satisfied on next edge
        for (int i = 0; i < 3; i++) tick(16'h0000, 1'b0);
        chk("hold_stall_dout", 64'(bus.data_out), 64'h0001);
        tick(16'h0000, 1'b1);
        chk("hold_release_dout", 64'(bus.data_out), 64'h0000);

        // Timeout in PRD then successful second attempt
        do_reset();
        for (int i = 0; i < 6; i++) tick(16'h0000, 1'b1);   // -> PRD
        for (int i = 0; i < 19; i++) tick(16'h0000, 1'b1);
        chk("to_prd_still", 64'(bus.address), 64'h022E);
        tick(16'h0000, 1'b1);
        chk("to_back_w1", 64'({bus.address, bus.data_out}), 64'({16'h0226, 16'h0001}));
        chk("to_retry1", 64'(retry_count), 64'd1);
        apply_rows(14);
        chk("to_done_version", 64'(dsp_version), 64'h0405);
        chk("to_done_error", 64'(error), 64'd0);
        chk("to_done_retry", 64'(retry_count), 64'd1);

        // Success exit on the timeout edge wins
        do_reset();
        for (int i = 0; i < 6; i++) tick(16'h0000, 1'b1);
        for (int i = 0; i < 19; i++) tick(16'h0000, 1'b1);
        tick(16'h0080, 1'b1);
        chk("race_to_raa", 64'(bus.address), 64'h022A);
        chk("race_no_retry", 64'(retry_count), 64'd0);

        // Exhaustion: three 26-edge attempts then FAIL
        do_reset();
        n = 0;
        while (busy && n < 200) begin
            tick(16'h0000, 1'b1);
            n++;
        end
        chk("exh_edges", 64'(n), 64'd78);
        chk("exh_outputs", 64'(obs()), 64'({16'h0226, 16'h0000, 1'b1, 1'b0, 1'b0}));
        chk("exh_error", 64'(error), 64'd1);
        chk("exh_retry", 64'(retry_count), 64'd2);

        // Asynchronous reset while in PV1
        do_reset();
        apply_rows(10);
        rst_n = 1'b0;
        #1;
        chk("async_outputs", 64'(obs()), 64'({16'h0226, 16'h0001, 1'b1, 1'b0, 1'b1}));
        chk("async_version", 64'(dsp_version), 64'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Tri-state release; machine keeps running
        bus.enable = 1'b0;
        tick(16'h0000, 1'b1);
        checks++;
        if (!(bus.address === 16'bz)) begin failures++; $display("FAIL z_address actual=%h required=zzzz", bus.address); end
        checks++;
        if (!(bus.data_out === 16'bz)) begin failures++; $display("FAIL z_data_out actual=%h required=zzzz", bus.data_out); end
        checks++;
        if (!(bus.data_dir === 1'bz)) begin failures++; $display("FAIL z_data_dir actual=%b required=z", bus.data_dir); end
        checks++;
        if (!(bus.accepted === 1'bz)) begin failures++; $display("FAIL z_accepted actual=%b required=z", bus.accepted); end
        chk("z_busy_driven", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) tick(16'h0000, 1'b1);   // HOLD -> W0 while disabled
        bus.enable = 1'b1;
        #1;
        chk("z_reenable_w0", 64'({bus.address, bus.data_out}), 64'({16'h0226, 16'h0000}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsp_reset_sequencer.md
Name: dsp_reset_sequencer

Overview:
Parametrised successor to the fixed DSP reset sequencer on the CT2960 riser. It drives the Sound Blaster DSP reset handshake with configurable timing and a poll timeout, retries on failure, and reads back the DSP version (command E1h) before reporting completion. It sits between the riser's bus-cycle arbiter, which gates it with enable and paces it with bus_step, and the ISA-side address/data drivers.

Parameters:
BASE_ADDRESS, 16'h0220, DSP base I/O address; all ports are offsets from it.
CNT_W, 16, width of the shared cycle counter.
RESET_HOLD_CYCLES, 150, sys_clock cycles reset=1 is held (3 us at 50 MHz).
POLL_TIMEOUT_CYCLES, 5000, sys_clock cycles allowed in any poll state before a timeout.
MAX_RETRIES, 3, full-sequence retries after the first attempt before FAIL; 0 means no retry.
READ_VERSION, 1, 1 = run the E1h version read after AAh; 0 = go to DONE straight after AAh.

Ports:
sys_clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  synchronous restart pulse; honoured in any state
bus_step  in  1  bus-cycle strobe; state advances only on edges where it is 1 (timeout excepted)
enable  in  1  output enable; 0 puts data_out, address, data_dir and accepted at Z
data_in  in  16  read data from the bus
data_out  out  16  write data (tri-state)
address  out  16  bus address (tri-state)
data_dir  out  1  1 = write, 0 = read (tri-state)
accepted  out  1  1 in DONE only (tri-state)
busy  out  1  1 in every state except DONE and FAIL
error  out  1  registered, set on entry to FAIL
retry_count  out  3  registered count of retries performed
dsp_version  out  16  registered {major, minor}; captured from data_in[7:0]

Behaviour:
- Port offsets: RST = +6h, RDATA = +Ah, WCMD/WSTAT = +Ch, RSTAT = +Eh.
- States and Moore outputs (address, data_out, data_dir):
  - W1 (RST, 0001h, 1) -> HOLD on bus_step.
  - HOLD (RST, 0001h, 1) -> W0 when cnt >= RESET_HOLD_CYCLES and bus_step.
  - W0 (RST, 0000h, 1) -> PRD on bus_step.
  - PRD (RSTAT, 0, 0) -> RAA when data_in[7]=1 and bus_step.
  - RAA (RDATA, 0, 0) -> PWR when data_in=00AAh and bus_step, or DONE if READ_VERSION=0.
  - PWR (WSTAT, 0, 0) -> WE1 when data_in[7]=0 and bus_step.
  - WE1 (WCMD, 00E1h, 1) -> PV1 on bus_step.
  - PV1 (RSTAT, 0, 0) -> RV1 on data_in[7]=1 and bus_step.
  - RV1 (RDATA, 0, 0) -> PV2 on bus_step; latches dsp_version[15:8]=data_in[7:0].
  - PV2 (RSTAT, 0, 0) -> RV2 on data_in[7]=1 and bus_step.
  - RV2 (RDATA, 0, 0) -> DONE on bus_step; latches dsp_version[7:0].
  - DONE (RST, 0000h, 1), accepted=1; holds until start.
  - FAIL (RST, 0000h, 1), accepted=0; holds until start.
- Counter: cleared on every state change; increments every sys_clock in HOLD and in the poll states (PRD, RAA, PWR, PV1, PV2); saturates at all-ones.
- Timeout: in a poll state with cnt = POLL_TIMEOUT_CYCLES-1 and no qualifying exit on that edge:
  - if retry_count < MAX_RETRIES: retry_count+1, go to W1;
  - else: go to FAIL, error=1.
  - A timeout does not need bus_step. A success exit on the same edge wins over the timeout.
- RAA with bus_step and data_in != 00AAh: stays in RAA; still subject to timeout.
- start=1: next edge goes to W1, clears retry_count, error, dsp_version and cnt; overrides all other transitions.
- reset_n=0 (asynchronous, mid-sequence allowed): state=W1, cnt=0, retry_count=0, error=0, dsp_version=0000h. With enable=1: address=BASE+6h, data_out=0001h, data_dir=1, accepted=0, busy=1. On release the sequence starts automatically.
- enable only gates the tri-states. The state machine keeps running when enable=0.

Test Plan:
Use RESET_HOLD_CYCLES=4, POLL_TIMEOUT_CYCLES=20, MAX_RETRIES=2, BASE=0220h, bus_step=1 unless stated.
- Nominal: status 80h then 00AAh, then WSTAT 00h, 80h/0004h, 80h/0005h -> address sequence 0226, 0226, 0226, 022E, 022A, 022C, 022C (data E1h), 022E, 022A, 022E, 022A; DONE with accepted=1, dsp_version=0405h, busy=0, retry_count=0.
- HOLD timing: bus_step stuck at 1 -> W0 is entered exactly 4 sys_clock edges after entering HOLD; bus_step=0 at that point -> HOLD persists until bus_step returns.
- Timeout then recover: RSTAT stays 00h for 20 cycles -> back to W1 with retry_count=1; second attempt succeeds -> DONE, error=0.
- Exhaustion: data_in=0000h throughout -> three attempts, then FAIL with error=1, retry_count=2, accepted=0.
- Edge race: data_in[7]=1 arrives with bus_step on the edge where cnt=19 in PRD -> goes to RAA, no retry.
- Reset/start mid-run: reset_n low while in PV1 -> outputs return to reset values immediately; start pulse in DONE -> W1 with dsp_version=0000h; enable=0 -> all four tri-state outputs read Z.
